// File: rtl/ctrl_pkt_pkg.sv
// Shared definitions for the RMT control path: header layout, FSM states and
// the stage/unit module-ID packing used by both the generator and the receivers.
package ctrl_pkt_pkg;

  localparam logic [15:0] CTRL_UDP_PORT = 16'hF1F2;

  // Byte offsets within the header beat (byte n = tdata[8n+7:8n])
  localparam int OFF_DST_MAC  = 0;
  localparam int OFF_SRC_MAC  = 6;
  localparam int OFF_ETHTYPE  = 12;
  localparam int OFF_IP_VER   = 14;
  localparam int OFF_IP_LEN   = 16;
  localparam int OFF_IP_TTL   = 22;
  localparam int OFF_IP_PROTO = 23;
  localparam int OFF_UDP_SRC  = 34;
  localparam int OFF_UDP_DST  = 36;
  localparam int OFF_UDP_LEN  = 38;
  localparam int OFF_MOD_ID   = 42;
  localparam int OFF_INDEX    = 43;
  localparam int OFF_SEQ      = 44;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [15:0] IP_TOTAL_LEN = 16'd114;
  localparam logic [7:0]  IP_TTL       = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
  localparam logic [15:0] UDP_LEN      = 16'd94;
  localparam logic [15:0] PKT_BYTES    = 16'd128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_GAP
  } state_t;

  function automatic logic [7:0] mod_id(input logic [4:0] stage_id, input logic [2:0] unit);
    return {stage_id, unit};
  endfunction

endpackage

// File: rtl/ctrl_hdr_build.sv
// Combinational assembly of the Ethernet/IPv4/UDP control header beat.
// Multi-byte fields are written big-endian; unlisted bytes are zero.
module ctrl_hdr_build
  import ctrl_pkt_pkg::*;
#(
  parameter int          DATA_W   = 512,
  parameter logic [15:0] UDP_PORT = 16'hF1F2,
  parameter logic [47:0] DST_MAC  = 48'h0,
  parameter logic [47:0] SRC_MAC  = 48'h0
) (
  input  logic [4:0]        stage_id,
  input  logic [2:0]        unit,
  input  logic [7:0]        index,
  input  logic [15:0]       seq,
  output logic [DATA_W-1:0] hdr
);

  always_comb begin
    hdr = '0;
    for (int i = 0; i < 6; i++) begin
      hdr[8*(OFF_DST_MAC+i) +: 8] = DST_MAC[8*(5-i) +: 8];
      hdr[8*(OFF_SRC_MAC+i) +: 8] = SRC_MAC[8*(5-i) +: 8];
    end
    hdr[8*OFF_ETHTYPE     +: 8] = ETHTYPE_IPV4[15:8];
    hdr[8*(OFF_ETHTYPE+1) +: 8] = ETHTYPE_IPV4[7:0];
    hdr[8*OFF_IP_VER      +: 8] = IP_VER_IHL;
    hdr[8*OFF_IP_LEN      +: 8] = IP_TOTAL_LEN[15:8];
    hdr[8*(OFF_IP_LEN+1)  +: 8] = IP_TOTAL_LEN[7:0];
    hdr[8*OFF_IP_TTL      +: 8] = IP_TTL;
    hdr[8*OFF_IP_PROTO    +: 8] = IP_PROTO_UDP;
    hdr[8*OFF_UDP_SRC     +: 8] = UDP_PORT[15:8];
    hdr[8*(OFF_UDP_SRC+1) +: 8] = UDP_PORT[7:0];
    hdr[8*OFF_UDP_DST     +: 8] = UDP_PORT[15:8];
    hdr[8*(OFF_UDP_DST+1) +: 8] = UDP_PORT[7:0];
    hdr[8*OFF_UDP_LEN     +: 8] = UDP_LEN[15:8];
    hdr[8*(OFF_UDP_LEN+1) +: 8] = UDP_LEN[7:0];
    hdr[8*OFF_MOD_ID      +: 8] = mod_id(stage_id, unit);
    hdr[8*OFF_INDEX       +: 8] = index;
    hdr[8*OFF_SEQ         +: 8] = seq[15:8];
    hdr[8*(OFF_SEQ+1)     +: 8] = seq[7:0];
  end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Turns table-write commands into paced 2-beat AXIS control packets (header, entry).
// The downstream path has no tready, so a fixed idle gap follows every packet.
module ctrl_pkt_gen #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          NUM_STAGES           = 5,
  parameter int          GAP_CYCLES           = 4,
  parameter logic [7:0]  SRC_PORT             = 8'h01,
  parameter logic [15:0] CTRL_UDP_PORT        = ctrl_pkt_pkg::CTRL_UDP_PORT,
  parameter logic [47:0] DST_MAC              = 48'h0,
  parameter logic [47:0] SRC_MAC              = 48'h0
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [4:0]                        cmd_stage_id,
  input  logic [2:0]                        cmd_unit,
  input  logic [7:0]                        cmd_index,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    cmd_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic                              busy,
  output logic [31:0]                       pkt_cnt,
  output logic [15:0]                       err_cnt
);
  import ctrl_pkt_pkg::*;

  localparam int DATA_W  = C_S_AXIS_DATA_WIDTH;
  localparam int TUSER_W = C_S_AXIS_TUSER_WIDTH;
  localparam int KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t              state_reg, state_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [15:0]         seq_reg, seq_next;
  logic [31:0]         pkt_cnt_reg, pkt_cnt_next;
  logic [15:0]         err_cnt_reg, err_cnt_next;
  logic                cmd_ready_reg, cmd_ready_next;
  logic                busy_reg;
  logic [DATA_W-1:0]   tdata_reg, tdata_next;
  logic [TUSER_W-1:0]  tuser_reg, tuser_next;
  logic [KEEP_W-1:0]   tkeep_reg, tkeep_next;
  logic                tvalid_reg, tvalid_next;
  logic                tlast_reg, tlast_next;

  logic [4:0]          stage_reg;
  logic [2:0]          unit_reg;
  logic [7:0]          index_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                latch_en;
  logic                stage_ok;
  logic [DATA_W-1:0]   hdr;

  assign stage_ok = (32'(cmd_stage_id) < NUM_STAGES);

  ctrl_hdr_build #(
    .DATA_W   (DATA_W),
    .UDP_PORT (CTRL_UDP_PORT),
    .DST_MAC  (DST_MAC),
    .SRC_MAC  (SRC_MAC)
  ) u_hdr (
    .stage_id (stage_reg),
    .unit     (unit_reg),
    .index    (index_reg),
    .seq      (seq_reg),
    .hdr      (hdr)
  );

  // Beat registers are loaded from the state being left, so a beat shows up one edge after its state
  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    seq_next       = seq_reg;
    pkt_cnt_next   = pkt_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    cmd_ready_next = 1'b0;
    tdata_next     = '0;
    tuser_next     = '0;
    tkeep_next     = '0;
    tvalid_next    = 1'b0;
    tlast_next     = 1'b0;
    latch_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready_next = 1'b1;
        if (cmd_valid && cmd_ready_reg) begin
          if (stage_ok) begin
            state_next     = ST_HDR;
            cmd_ready_next = 1'b0;
            latch_en       = 1'b1;
          end else if (err_cnt_reg != 16'hFFFF) begin
            err_cnt_next = err_cnt_reg + 16'd1;
          end
        end
      end
      ST_HDR: begin
        tdata_next  = hdr;
        tuser_next  = {{(TUSER_W-24){1'b0}}, SRC_PORT, PKT_BYTES};
        tkeep_next  = {KEEP_W{1'b1}};
        tvalid_next = 1'b1;
        state_next  = ST_DATA;
      end
      ST_DATA: begin
        tdata_next   = data_reg;
        tuser_next   = {{(TUSER_W-24){1'b0}}, SRC_PORT, PKT_BYTES};
        tkeep_next   = {KEEP_W{1'b1}};
        tvalid_next  = 1'b1;
        tlast_next   = 1'b1;
        pkt_cnt_next = pkt_cnt_reg + 32'd1;
        seq_next     = seq_reg + 16'd1;
        if (GAP_CYCLES == 0) begin
          state_next     = ST_IDLE;
          cmd_ready_next = 1'b1;
        end else begin
          state_next   = ST_GAP;
          gap_cnt_next = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next     = ST_IDLE;
          cmd_ready_next = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= ST_IDLE;
      gap_cnt_reg   <= '0;
      seq_reg       <= '0;
      pkt_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      tdata_reg     <= '0;
      tuser_reg     <= '0;
      tkeep_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      stage_reg     <= '0;
      unit_reg      <= '0;
      index_reg     <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      seq_reg       <= seq_next;
      pkt_cnt_reg   <= pkt_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      cmd_ready_reg <= cmd_ready_next;
      busy_reg      <= (state_next != ST_IDLE);
      tdata_reg     <= tdata_next;
      tuser_reg     <= tuser_next;
      tkeep_reg     <= tkeep_next;
      tvalid_reg    <= tvalid_next;
      tlast_reg     <= tlast_next;
      if (latch_en) begin
        stage_reg <= cmd_stage_id;
        unit_reg  <= cmd_unit;
        index_reg <= cmd_index;
        data_reg  <= cmd_data;
      end
    end
  end

  assign cmd_ready       = cmd_ready_reg;
  assign busy            = busy_reg;
  assign pkt_cnt         = pkt_cnt_reg;
  assign err_cnt         = err_cnt_reg;
  assign c_m_axis_tdata  = tdata_reg;
  assign c_m_axis_tuser  = tuser_reg;
  assign c_m_axis_tkeep  = tkeep_reg;
  assign c_m_axis_tvalid = tvalid_reg;
  assign c_m_axis_tlast  = tlast_reg;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Directed bench for ctrl_pkt_gen: a gapped instance (GAP_CYCLES=4) and a
// gapless one (GAP_CYCLES=0), checked against hand-computed packets.
module tb_ctrl_pkt_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aresetn;
  logic         cmd_valid, cmd_valid0;
  logic [4:0]   cmd_stage_id;
  logic [2:0]   cmd_unit;
  logic [7:0]   cmd_index;
  logic [511:0] cmd_data;

  logic         cmd_ready, tvalid, tlast, busy;
  logic [511:0] tdata;
  logic [127:0] tuser;
  logic [63:0]  tkeep;
  logic [31:0]  pkt_cnt;
  logic [15:0]  err_cnt;

  logic         cmd_ready0, tvalid0, tlast0, busy0;
  logic [511:0] tdata0;
  logic [127:0] tuser0;
  logic [63:0]  tkeep0;
  logic [31:0]  pkt_cnt0;
  logic [15:0]  err_cnt0;

  ctrl_pkt_gen #(.GAP_CYCLES(4)) dut (
    .axis_clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_stage_id(cmd_stage_id), .cmd_unit(cmd_unit), .cmd_index(cmd_index), .cmd_data(cmd_data),
    .c_m_axis_tdata(tdata), .c_m_axis_tuser(tuser), .c_m_axis_tkeep(tkeep),
    .c_m_axis_tvalid(tvalid), .c_m_axis_tlast(tlast),
    .busy(busy), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  ctrl_pkt_gen #(.GAP_CYCLES(0)) dut0 (
    .axis_clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_stage_id(cmd_stage_id), .cmd_unit(cmd_unit), .cmd_index(cmd_index), .cmd_data(cmd_data),
    .c_m_axis_tdata(tdata0), .c_m_axis_tuser(tuser0), .c_m_axis_tkeep(tkeep0),
    .c_m_axis_tvalid(tvalid0), .c_m_axis_tlast(tlast0),
    .busy(busy0), .pkt_cnt(pkt_cnt0), .err_cnt(err_cnt0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]  exp_seq;
  logic [31:0]  exp_pkt;
  logic [15:0]  exp_err;
  logic [127:0] exp_tuser;

  typedef struct {
    logic [4:0]   stage;
    logic [2:0]   unit;
    logic [7:0]   index;
    logic [511:0] data;
    bit           ok;
    logic [7:0]   b42;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_hdr(input logic [7:0] b42, input logic [7:0] idx,
                                           input logic [15:0] seq);
    logic [7:0]   b [64];
    logic [511:0] h;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    b[12] = 8'h08; b[14] = 8'h45; b[17] = 8'h72; b[22] = 8'h40; b[23] = 8'h11;
    b[34] = 8'hF1; b[35] = 8'hF2; b[36] = 8'hF1; b[37] = 8'hF2; b[39] = 8'h5E;
    b[42] = b42; b[43] = idx; b[44] = seq[15:8]; b[45] = seq[7:0];
    for (int i = 0; i < 64; i++) h[8*i +: 8] = b[i];
    return h;
  endfunction

  // One command on the gapped instance, checked beat by beat
  task automatic do_cmd(input vec_t v);
    int n;
    @(negedge clk);
    cmd_stage_id = v.stage; cmd_unit = v.unit; cmd_index = v.index; cmd_data = v.data;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 1'b0, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~v.data;
    cmd_index = ~v.index;
    $display("cmd stage=%0d unit=%0d index=%02h ok=%0b seq=%04h", v.stage, v.unit, v.index, v.ok, exp_seq);
    if (v.ok) begin
      chk("ready_low", cmd_ready, 1'b0);
      chk("busy_high", busy, 1'b1);
      chk("no_early_beat", tvalid, 1'b0);
      @(negedge clk);
      chk("hdr_tvalid", tvalid, 1'b1);
      chk("hdr_tlast", tlast, 1'b0);
      chk("hdr_tdata", tdata, exp_hdr(v.b42, v.index, exp_seq));
      chk("hdr_tuser", tuser, exp_tuser);
      chk("hdr_tkeep", tkeep, {64{1'b1}});
      @(negedge clk);
      exp_pkt++;
      exp_seq++;
      chk("data_tvalid", tvalid, 1'b1);
      chk("data_tlast", tlast, 1'b1);
      chk("data_tdata", tdata, v.data);
      chk("pkt_cnt", pkt_cnt, exp_pkt);
      @(negedge clk);
      chk("gap_tvalid", tvalid, 1'b0);
      chk("gap_tkeep", tkeep, 64'd0);
      chk("gap_ready", cmd_ready, 1'b0);
    end else begin
      exp_err++;
      chk("drop_ready", cmd_ready, 1'b1);
      chk("drop_err_cnt", err_cnt, exp_err);
      chk("drop_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      chk("drop_no_beat", tvalid, 1'b0);
      chk("drop_pkt_cnt", pkt_cnt, exp_pkt);
    end
  endtask

  // cmd_valid held high for three commands; records accept and header timing
  task automatic run_burst(input bit sel, input int exp_sp, input logic [15:0] seq0);
    int          acc [3];
    int          hcy [3];
    logic [15:0] hseq [3];
    int          n_acc, n_hdr, n_beats;
    bit          drop, rdy, vld, tv, tl;
    logic [511:0] td;
    n_acc = 0; n_hdr = 0; n_beats = 0; drop = 1'b0;
    @(negedge clk);
    cmd_stage_id = 5'd1; cmd_unit = 3'd2; cmd_index = 8'h33; cmd_data = {16{32'h5A5AC3C3}};
    if (sel) cmd_valid0 = 1'b1; else cmd_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      rdy = sel ? cmd_ready0 : cmd_ready;
      vld = sel ? cmd_valid0 : cmd_valid;
      tv  = sel ? tvalid0 : tvalid;
      tl  = sel ? tlast0 : tlast;
      td  = sel ? tdata0 : tdata;
      if (tv) n_beats++;
      if (tv && !tl && n_hdr < 3) begin
        hcy[n_hdr]  = cyc;
        hseq[n_hdr] = {td[359:352], td[367:360]};
        n_hdr++;
      end
      if (vld && rdy && n_acc < 3) begin
        acc[n_acc] = cyc + 1;
        $display("burst gap=%0d accept %0d at edge %0d", exp_sp - 3, n_acc, acc[n_acc]);
        n_acc++;
        if (n_acc == 3) drop = 1'b1;
      end
      @(negedge clk);
      if (drop) begin
        cmd_valid  = 1'b0;
        cmd_valid0 = 1'b0;
        drop = 1'b0;
      end
    end
    cmd_valid  = 1'b0;
    cmd_valid0 = 1'b0;
    chk("burst_accepts", n_acc, 3);
    chk("burst_headers", n_hdr, 3);
    chk("burst_beats", n_beats, 6);
    if (n_acc == 3) begin
      chk("burst_spacing1", acc[1] - acc[0], exp_sp);
      chk("burst_spacing2", acc[2] - acc[1], exp_sp);
    end
    for (int k = 0; k < n_hdr && k < n_acc; k++) begin
      chk("burst_hdr_time", hcy[k], acc[k] + 1);
      chk("burst_seq", hseq[k], seq0 + 16'(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tuser = {104'd0, 8'h01, 16'd128};
    exp_seq = 16'd0; exp_pkt = 32'd0; exp_err = 16'd0;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_valid0 = 1'b0;
    cmd_stage_id = '0; cmd_unit = '0; cmd_index = '0; cmd_data = '0;

    vecs[0] = '{5'd2,  3'd3, 8'h15, {64{8'hA5}},             1'b1, 8'h13};
    vecs[1] = '{5'd7,  3'd1, 8'h20, {64{8'h11}},             1'b0, 8'h39};
    vecs[2] = '{5'd0,  3'd0, 8'h00, {16{32'hDEADBEEF}},      1'b1, 8'h00};
    vecs[3] = '{5'd4,  3'd7, 8'hFF, {8{64'h0123456789ABCDEF}}, 1'b1, 8'h27};
    vecs[4] = '{5'd5,  3'd2, 8'h44, {64{8'h22}},             1'b0, 8'h2A};
    vecs[5] = '{5'd31, 3'd7, 8'h55, {64{8'h33}},             1'b0, 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 512'd0);
    chk("rst_tuser", tuser, 128'd0);
    chk("rst_tkeep", tkeep, 64'd0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    for (int i = 0; i < 6; i++) do_cmd(vecs[i]);
    // a valid command right after a dropped one still emits
    do_cmd(vecs[2]);

    run_burst(1'b0, 7, exp_seq);
    exp_seq = exp_seq + 16'd3;
    exp_pkt = exp_pkt + 32'd3;
    repeat (8) @(negedge clk);

    // sequence-number wrap
    force dut.seq_reg = 16'hFFFF;
    @(negedge clk);
    release dut.seq_reg;
    exp_seq = 16'hFFFF;
    do_cmd(vecs[3]);
    chk("seq_wrapped", exp_seq, 16'h0000);
    do_cmd(vecs[0]);

    // reset in the middle of a packet
    @(negedge clk);
    cmd_stage_id = 5'd3; cmd_unit = 3'd1; cmd_index = 8'h77; cmd_data = {64{8'h5C}};
    cmd_valid = 1'b1;
    for (int n = 0; n < 50 && cmd_ready !== 1'b1; n++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("prerst_hdr_tvalid", tvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    $display("async reset asserted mid-packet");
    chk("arst_tvalid", tvalid, 1'b0);
    chk("arst_tlast", tlast, 1'b0);
    chk("arst_tdata", tdata, 512'd0);
    chk("arst_tuser", tuser, 128'd0);
    chk("arst_tkeep", tkeep, 64'd0);
    chk("arst_ready", cmd_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pkt_cnt", pkt_cnt, 32'd0);
    chk("arst_err_cnt", err_cnt, 16'd0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", cmd_ready, 1'b1);
    exp_seq = 16'd0; exp_pkt = 32'd0; exp_err = 16'd0;
    do_cmd(vecs[0]);

    // gapless instance
    run_burst(1'b1, 3, 16'd0);
    chk("gap0_pkt_cnt", pkt_cnt0, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
